// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and
// default sizing used by the top level and its response FIFO.
package instr_fetch_unit_pkg;

    // Default datapath width and buffered-entry count
    localparam int FETCH_XLEN_DEFAULT = 32;
    localparam int FETCH_FIFO_DEPTH   = 2;

    // Fetch FSM encodings
    localparam logic [0:0] FETCH_ST_FETCH = 1'b0;
    localparam logic [0:0] FETCH_ST_DRAIN = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO holding {pc, instr} fetch responses. The head entry
// comes straight from the storage registers so decode sees registered data.
// A push while full is only legal alongside a pop; the fetch request logic
// guarantees that, so no overflow protection is needed here.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 2 * FETCH_XLEN_DEFAULT,
    parameter int DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Popping an empty FIFO is ignored; clear wins over any push
    assign do_pop  = pop && (count != '0);
    assign do_push = push && !clear;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage, cleared on reset so the presented head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage between the program counter and decode. Issues one
// instruction-memory read at a time at the current PC, pulses pc_en when a
// request is granted (or on redirect), buffers responses with their PC and
// hands them to decode over valid/ready. A flush discards everything buffered
// and any response still owed by the memory.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN       = FETCH_XLEN_DEFAULT,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [0:0]        state;
    logic              outstanding;
    logic [XLEN-1:0]   pc_q;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occupancy;
    logic [2*XLEN-1:0] head;
    logic              has_space;
    logic              grant;
    logic              push;
    logic              pop;

    assign if_valid = (count != '0);
    assign pop      = if_valid && if_ready;
    assign if_pc    = head[2*XLEN-1:XLEN];
    assign if_instr = head[XLEN-1:0];

    // Slots already claimed (buffered plus owed) once this cycle's pop leaves
    assign occupancy = count + CW'(outstanding) - CW'(pop);
    assign has_space = (occupancy < CW'(FIFO_DEPTH));

    // Word-aligned address; request only when a slot is guaranteed for the
    // response and no other response is still pending
    assign imem_addr = {pc[XLEN-1:2], 2'b00};
    assign imem_req  = !rst && (state == FETCH_ST_FETCH) && !flush &&
                       (!outstanding || imem_rvalid) && has_space;
    assign grant     = imem_req && imem_gnt;
    assign pc_en     = !rst && (flush || grant);

    // Responses are kept only in normal operation and never on a redirect
    assign push = (state == FETCH_ST_FETCH) && imem_rvalid && !flush;

    // Track whether a granted request is still waiting for its response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else if (grant) begin
            outstanding <= 1'b1;
        end else if (imem_rvalid) begin
            outstanding <= 1'b0;
        end
    end

    // Remember the PC of the granted request to tag its response
    always_ff @(posedge clk) begin
        if (grant) begin
            pc_q <= pc;
        end
    end

    // FETCH/DRAIN control: a flush with a response still owed must swallow it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_ST_FETCH;
        end else begin
            case (state)
                FETCH_ST_FETCH: begin
                    if (flush && outstanding && !imem_rvalid) begin
                        state <= FETCH_ST_DRAIN;
                    end
                end
                FETCH_ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state <= FETCH_ST_FETCH;
                    end
                end
                default: state <= FETCH_ST_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({pc_q, imem_rdata}),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run.
// The bench plays the program counter and a single-outstanding memory with
// variable latency, and keeps an expected queue of instructions owed to decode.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    instr_fetch_unit #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    int          tests = 0;
    int          fails = 0;
    item_t       exp_q[$];
    bit          mem_busy;
    bit          mem_dropped;
    int          mem_wait;
    int          mem_lat;
    logic [31:0] mem_addr;
    bit          dead_mode;
    logic        samp_req;
    logic        samp_pcen;
    logic        samp_valid;
    logic [31:0] last_pop_pc;
    int          pops;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mem_busy    = 0;
        mem_dropped = 0;
        mem_wait    = 0;
        mem_lat     = 1;
        dead_mode   = 0;
        pops        = 0;
        last_pop_pc = '0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance models
    task automatic tick(input logic g, input logic r, input logic f, input logic [31:0] tgt);
        logic [31:0] pc_next;
        logic [31:0] data;
        item_t       it;
        bit          rv;
        rv   = mem_busy && (mem_wait == 0);
        data = rv ? (dead_mode ? 32'h0000_DEAD : mem_word(mem_addr)) : $urandom;
        imem_gnt    = g;
        if_ready    = r;
        flush       = f;
        imem_rvalid = rv;
        imem_rdata  = data;
        @(negedge clk);
        samp_req   = imem_req;
        samp_pcen  = pc_en;
        samp_valid = if_valid;
        chk("imem_addr", imem_addr, {pc[31:2], 2'b00});
        chk("pc_en", pc_en, f | (imem_req & g));
        chk("one_outstanding", imem_req & mem_busy & ~rv, 0);
        chk("drain_no_req", imem_req & mem_busy & mem_dropped, 0);
        if (f) chk("flush_no_req", imem_req, 0);
        chk("if_valid", if_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("if_pc", if_pc, exp_q[0].pc);
            chk("if_instr", if_instr, exp_q[0].instr);
        end
        pc_next = pc;
        if (pc_en === 1'b1) pc_next = f ? tgt : pc + 32'd4;
        if (f) begin
            exp_q.delete();
        end else if (r && exp_q.size() != 0) begin
            last_pop_pc = exp_q[0].pc;
            pops++;
            void'(exp_q.pop_front());
        end
        if (rv) begin
            if (!f && !mem_dropped) begin
                it.pc    = mem_addr;
                it.instr = data;
                exp_q.push_back(it);
            end
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_wait--;
            if (f) mem_dropped = 1;
        end
        if (imem_req === 1'b1 && g) begin
            mem_busy    = 1;
            mem_dropped = 0;
            mem_addr    = pc;
            mem_wait    = mem_lat - 1;
        end
        chk("fifo_bound", exp_q.size() <= 2, 1);
        @(posedge clk);
        #1;
        pc = pc_next;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst         = 1'b1;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        pc          = start_pc;
        @(negedge clk);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_addr", imem_addr, {start_pc[31:2], 2'b00});
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pc  = '0;
        model_clear();
        @(posedge clk);
        #1;

        // 1: streaming at one instruction per cycle
        do_reset(32'h0);
        for (int i = 0; i < 6; i++) begin
            tick(1, 1, 0, 0);
            chk("stream_pc_en", samp_pcen, 1);
        end
        chk("stream_pops", pops, 4);
        chk("stream_last_pc", last_pop_pc, 32'hC);

        // 2: backpressure fills two entries then stops fetching
        do_reset(32'h0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
        chk("bp_req_stop", samp_req, 0);
        chk("bp_pcen_stop", samp_pcen, 0);
        chk("bp_valid", samp_valid, 1);
        tick(1, 1, 0, 0);
        chk("bp_pop0", last_pop_pc, 32'h0);
        chk("bp_resume_req", samp_req, 1);
        tick(1, 1, 0, 0);
        chk("bp_pop4", last_pop_pc, 32'h4);
        tick(1, 1, 0, 0);
        chk("bp_pop8", last_pop_pc, 32'h8);

        // 3: flush with a response still in flight
        do_reset(32'h8);
        mem_lat = 3;
        tick(1, 1, 0, 0);
        mem_lat   = 1;
        dead_mode = 1;
        tick(0, 1, 1, 32'h100);
        chk("fl_pc_en", samp_pcen, 1);
        tick(1, 1, 0, 0);
        chk("drain_req_a", samp_req, 0);
        tick(1, 1, 0, 0);
        chk("drain_req_b", samp_req, 0);
        dead_mode = 0;
        tick(1, 1, 0, 0);
        chk("fl_new_req", samp_req, 1);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("fl_first_pc", last_pop_pc, 32'h100);
        chk("fl_pops", pops, 1);

        // 4: flush in the same cycle as the response
        do_reset(32'h40);
        tick(1, 1, 0, 0);
        tick(1, 1, 1, 32'h200);
        chk("fr_pc_en", samp_pcen, 1);
        tick(1, 1, 0, 0);
        chk("fr_req", samp_req, 1);
        chk("fr_valid", samp_valid, 0);

        // 5: grant stall holds the request
        do_reset(32'h20);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            chk("gs_req", samp_req, 1);
            chk("gs_pcen", samp_pcen, 0);
            chk("gs_addr", imem_addr, 32'h20);
        end
        tick(1, 1, 0, 0);
        chk("gs_pulse", samp_pcen, 1);
        tick(0, 1, 0, 0);
        chk("gs_single", samp_pcen, 0);
        chk("gs_next_addr", imem_addr, 32'h24);

        // 6: asynchronous reset with the FIFO full
        do_reset(32'h80);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        @(negedge clk);
        chk("ar_pre_valid", if_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_if_valid", if_valid, 0);
        chk("ar_imem_req", imem_req, 0);
        chk("ar_pc_en", pc_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pc  = 32'h400;
        model_clear();
        tick(1, 1, 0, 0);
        chk("ar_restart_req", samp_req, 1);

        // Randomized traffic against the reference model
        do_reset(32'h0);
        for (int i = 0; i < 2000; i++) begin
            mem_lat = $urandom_range(1, 3);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, 32'($urandom_range(0, 1023)) << 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
